// File: rtl/spi_master.sv
// SPI mode-0 initiator for the header/address/data register-access protocol.
// One transaction per accepted start; every output comes straight from a flop.
module spi_master #(
  parameter int unsigned NB_DATA = 8,
  parameter int unsigned NB_ADDR = 8,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic               rw_i,
  input  logic [NB_ADDR-1:0] addr_i,
  input  logic [NB_DATA-1:0] wr_data_i,
  input  logic               miso_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [NB_DATA-1:0] rd_data_o,
  output logic               sclk_o,
  output logic               csb_o,
  output logic               mosi_o
);

  localparam int unsigned NBits = 2 * NB_DATA + NB_ADDR;
  localparam int unsigned CntW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BitW  = $clog2(NBits);
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);
  localparam logic [BitW-1:0] BitMax = BitW'(NBits - 1);

  typedef enum logic [1:0] {StIdle, StShift, StTrail, StGap} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [BitW-1:0]    bit_q, bit_d;
  logic [NBits-1:0]   tx_q, tx_d;
  logic [NB_DATA-1:0] rx_q, rx_d;
  logic               rw_q, rw_d;
  logic               sclk_q, sclk_d;
  logic               csb_q, csb_d;
  logic               mosi_q, mosi_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [NB_DATA-1:0] rd_data_q, rd_data_d;

  logic [NBits-1:0]   frame;
  logic               phase_end;

  // Header is all zeros except its LSB, which carries rw; reads send a zero data field.
  assign frame     = {{(NB_DATA-1){1'b0}}, rw_i, addr_i,
                      (rw_i ? {NB_DATA{1'b0}} : wr_data_i)};
  assign phase_end = (cnt_q == CntMax);

  always_comb begin
    state_d   = state_q;
    cnt_d     = phase_end ? '0 : cnt_q + CntW'(1);
    bit_d     = bit_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rw_d      = rw_q;
    sclk_d    = sclk_q;
    csb_d     = csb_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rd_data_d = rd_data_q;

    unique case (state_q)
      StIdle: begin
        cnt_d  = '0;
        csb_d  = 1'b1;
        sclk_d = 1'b0;
        mosi_d = 1'b0;
        busy_d = 1'b0;
        if (start_i) begin
          state_d = StShift;
          tx_d    = frame;
          rw_d    = rw_i;
          bit_d   = '0;
          csb_d   = 1'b0;
          busy_d  = 1'b1;
          mosi_d  = frame[NBits-1];
        end
      end
      StShift: begin
        if (phase_end) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
            rx_d   = {rx_q[NB_DATA-2:0], miso_i};
          end else begin
            sclk_d = 1'b0;
            if (bit_q == BitMax) begin
              state_d = StTrail;
              mosi_d  = 1'b0;
            end else begin
              bit_d  = bit_q + BitW'(1);
              tx_d   = tx_q << 1;
              mosi_d = tx_q[NBits-2];
            end
          end
        end
      end
      StTrail: begin
        if (phase_end) begin
          state_d = StGap;
          csb_d   = 1'b1;
        end
      end
      StGap: begin
        if (phase_end) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (rw_q) rd_data_d = rx_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rw_q      <= 1'b0;
      sclk_q    <= 1'b0;
      csb_q     <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rw_q      <= rw_d;
      sclk_q    <= sclk_d;
      csb_q     <= csb_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign rd_data_o = rd_data_q;
  assign sclk_o    = sclk_q;
  assign csb_o     = csb_q;
  assign mosi_o    = mosi_q;

endmodule
